mdu_hilo: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the register file: consumes the two read-port outputs (rs/rt data) in the execute stage.
- Executes MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO in one cycle.
- Exposes HI/LO for MFHI/MFLO writeback, plus a busy flag the hazard logic uses to stall.

---
 rtl/mdu_hilo.sv | 277 +++++++++++++++++++++++++++
 tb/tb_mdu_hilo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO registers.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   MDU_start  operation request, sampled on the rising edge
//   MDU_op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//              110/111 no-op
//   MDU_rs     rs operand (multiplicand / dividend / MT source)
//   MDU_rt     rt operand (multiplier / divisor)
//   MDU_busy   high while a mul/div is in progress (state != IDLE)
//   MDU_done   one-cycle pulse when HI/LO are written by a mul/div
//   MDU_hi     HI register
//   MDU_lo     LO register
//
// A mul/div walks IDLE -> CALC (ITER radix-2 steps) -> FIX (sign fix and
// HI/LO write). Signed operations iterate on magnitudes; the FIX edge
// restores the signs. MTHI/MTLO complete on their own edge while idle.

module mdu_hilo #(
    parameter int DATA_W = 32,
    parameter int ITER   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MDU_start,
    input  logic [2:0]        MDU_op,
    input  logic [DATA_W-1:0] MDU_rs,
    input  logic [DATA_W-1:0] MDU_rt,
    output logic              MDU_busy,
    output logic              MDU_done,
    output logic [DATA_W-1:0] MDU_hi,
    output logic [DATA_W-1:0] MDU_lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic req_md;
    logic req_mthi;
    logic req_mtlo;
    logic accept_md;
    logic wr_mthi;
    logic wr_mtlo;

    assign req_md   = MDU_start & ~MDU_op[2];
    assign req_mthi = MDU_start & (MDU_op == 3'b100);
    assign req_mtlo = MDU_start & (MDU_op == 3'b101);

    // FIX hands straight over to a new mul/div so a request on the
    // done edge loses no cycle. MT writes stay idle-only: on the FIX
    // edge they would collide with the result write.
    assign accept_md = req_md &
                       ((state_q == S_IDLE) || (state_q == S_FIX));
    assign wr_mthi   = req_mthi & (state_q == S_IDLE);
    assign wr_mtlo   = req_mtlo & (state_q == S_IDLE);

    // Operand preparation: signed ops iterate on magnitudes.
    logic              op_signed;
    logic              op_div;
    logic              rs_neg;
    logic              rt_neg;
    logic [DATA_W-1:0] rs_mag;
    logic [DATA_W-1:0] rt_mag;

    assign op_signed = ~MDU_op[0];
    assign op_div    = MDU_op[1];
    assign rs_neg    = op_signed & MDU_rs[DATA_W-1];
    assign rt_neg    = op_signed & MDU_rt[DATA_W-1];
    assign rs_mag    = rs_neg ? -MDU_rs : MDU_rs;
    assign rt_mag    = rt_neg ? -MDU_rt : MDU_rt;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    // acc_q: mul = {partial product high, multiplier shifting out},
    //        div = {remainder, dividend shifting out / quotient in}.
    // opnd_q: value added (mul) or subtracted (div) each step.
    logic [PW-1:0]     acc_q,  acc_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic [DATA_W-1:0] raw_q,  raw_d;
    logic              sa_q,   sa_d;
    logic              sb_q,   sb_d;
    logic              div_q,  div_d;
    logic              dz_q,   dz_d;
    logic [CW-1:0]     cnt_q,  cnt_d;
    logic [DATA_W-1:0] hi_q,   hi_d;
    logic [DATA_W-1:0] lo_q,   lo_d;
    logic              done_q, done_d;

    logic cnt_last;
    assign cnt_last = (cnt_q == CW'(ITER - 1));

    // ------------------------------------------------------------------
    // One radix-2 step
    // ------------------------------------------------------------------
    logic [DATA_W:0] mul_sum;
    logic [PW-1:0]   mul_next;
    logic [DATA_W:0] div_shift;
    logic [DATA_W:0] div_diff;
    logic [PW-1:0]   div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[PW-1:DATA_W]} +
                   (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
        mul_next = {mul_sum, acc_q[DATA_W-1:1]};

        // Restoring division: a borrow out of the trial subtract keeps
        // the shifted remainder and records a 0 quotient bit.
        div_shift = {acc_q[PW-1:DATA_W], acc_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[DATA_W]) begin
            div_next = {div_shift[DATA_W-1:0],
                        acc_q[DATA_W-2:0], 1'b0};
        end else begin
            div_next = {div_diff[DATA_W-1:0],
                        acc_q[DATA_W-2:0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and final HI/LO values
    // ------------------------------------------------------------------
    logic              res_neg;
    logic [PW-1:0]     prod_fix;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;

    always_comb begin
        res_neg  = sa_q ^ sb_q;
        prod_fix = res_neg ? -acc_q : acc_q;
        quo_fix  = res_neg ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        // Remainder follows the dividend's sign.
        rem_fix  = sa_q ? -acc_q[PW-1:DATA_W] : acc_q[PW-1:DATA_W];

        res_hi = prod_fix[PW-1:DATA_W];
        res_lo = prod_fix[DATA_W-1:0];
        if (div_q) begin
            if (dz_q) begin
                // Divide by zero: all-ones quotient, dividend as given.
                res_hi = raw_q;
                res_lo = {DATA_W{1'b1}};
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_md) state_d = S_CALC;
            end
            S_CALC: begin
                if (cnt_last) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = accept_md ? S_CALC : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        MDU_busy = (state_q != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        raw_d  = raw_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        div_d  = div_q;
        dz_d   = dz_q;
        cnt_d  = cnt_q;

        if (accept_md) begin
            opnd_d = op_div ? rt_mag : rs_mag;
            acc_d  = {{DATA_W{1'b0}}, (op_div ? rs_mag : rt_mag)};
            raw_d  = MDU_rs;
            sa_d   = rs_neg;
            sb_d   = rt_neg;
            div_d  = op_div;
            dz_d   = op_div & (MDU_rt == {DATA_W{1'b0}});
            cnt_d  = '0;
        end else if (state_q == S_CALC) begin
            acc_d = div_q ? div_next : mul_next;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if (state_q == S_FIX) begin
            hi_d   = res_hi;
            lo_d   = res_lo;
            done_d = 1'b1;
        end else begin
            if (wr_mthi) hi_d = MDU_rs;
            if (wr_mtlo) lo_d = MDU_rs;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            raw_q  <= '0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            div_q  <= 1'b0;
            dz_q   <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            raw_q  <= raw_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            div_q  <= div_d;
            dz_q   <= dz_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign MDU_hi   = hi_q;
    assign MDU_lo   = lo_q;
    assign MDU_done = done_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Testbench for mdu_hilo: directed and random mul/div/MT operations,
// expected HI/LO queued at issue and retired on each done pulse.

module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MDU_start;
    logic [2:0]  MDU_op;
    logic [31:0] MDU_rs;
    logic [31:0] MDU_rt;
    logic        MDU_busy;
    logic        MDU_done;
    logic [31:0] MDU_hi;
    logic [31:0] MDU_lo;

    mdu_hilo #(.DATA_W(32), .ITER(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MDU_start (MDU_start),
        .MDU_op    (MDU_op),
        .MDU_rs    (MDU_rs),
        .MDU_rt    (MDU_rt),
        .MDU_busy  (MDU_busy),
        .MDU_done  (MDU_done),
        .MDU_hi    (MDU_hi),
        .MDU_lo    (MDU_lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   t_iss;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op,
                                          input logic [31:0] rs,
                                          input logic [31:0] rt);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] a, b, q, r;
        case (op)
            3'd0: begin
                sp = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
                return sp;
            end
            3'd1: begin
                up = {32'b0, rs} * {32'b0, rt};
                return up;
            end
            3'd2: begin
                if (rt == 32'd0) return {rs, 32'hFFFFFFFF};
                if (rs == 32'h80000000 && rt == 32'hFFFFFFFF)
                    return {32'h0, 32'h80000000};
                a = rs;
                b = rt;
                q = a / b;
                r = a % b;
                return {r, q};
            end
            default: begin
                if (rt == 32'd0) return {rs, 32'hFFFFFFFF};
                return {rs % rt, rs / rt};
            end
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt);
        MDU_op    = op;
        MDU_rs    = rs;
        MDU_rt    = rt;
        MDU_start = 1'b1;
        step();
        MDU_start = 1'b0;
        t_iss     = cyc;
    endtask

    task automatic push(input string tag, input logic [31:0] hi,
                        input logic [31:0] lo);
        exp_t e;
        e.tag = tag;
        e.hi  = hi;
        e.lo  = lo;
        sb.push_back(e);
    endtask

    task automatic retire(input int t0);
        exp_t e;
        chk("latency", cyc - t0, 33);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_hi"}, MDU_hi, e.hi);
            chk({e.tag, "_lo"}, MDU_lo, e.lo);
        end
    endtask

    task automatic wait_done(input int t0, output int nb);
        bit got;
        got = 1'b0;
        nb  = 0;
        for (int i = 0; i < 80; i++) begin
            if (MDU_done) begin
                got = 1'b1;
                break;
            end
            if (MDU_busy) nb++;
            step();
        end
        chk("done_seen", got, 1);
        if (got) retire(t0);
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ehi, input logic [31:0] elo);
        int nb;
        push(tag, ehi, elo);
        issue(op, rs, rt);
        wait_done(t_iss, nb);
        chk({tag, "_busy_cycles"}, nb, 33);
        chk({tag, "_busy_after"}, MDU_busy, 0);
        step();
        chk({tag, "_done_pulse"}, MDU_done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          t0;
        int          t1;
        int          nb;
        bit          seen;
        logic [2:0]  rop;
        logic [31:0] rrs, rrt;
        logic [63:0] m;

        rst_n     = 1'b0;
        MDU_start = 1'b0;
        MDU_op    = 3'd0;
        MDU_rs    = '0;
        MDU_rt    = '0;
        repeat (2) step();
        chk("rst_busy", MDU_busy, 0);
        chk("rst_done", MDU_done, 0);
        chk("rst_hi", MDU_hi, 0);
        chk("rst_lo", MDU_lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7,
            32'hFFFFFFFF, 32'hFFFFFFEB);
        run("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 32'h00000001);
        run("mult_m1", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h00000000, 32'h00000001);
        run("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu_z", 3'd3, 32'd100, 32'd0,
            32'h00000064, 32'hFFFFFFFF);
        run("div_z", 3'd2, 32'hFFFFFF00, 32'd0,
            32'hFFFFFF00, 32'hFFFFFFFF);
        run("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF,
            32'h00000000, 32'h80000000);

        for (int k = 0; k < 6; k++) begin
            rop = 3'($urandom_range(0, 3));
            rrs = $urandom;
            rrt = $urandom;
            if (k % 2 == 1) rrt = rrt >> $urandom_range(0, 28);
            m = model(rop, rrs, rrt);
            run("rand", rop, rrs, rrt, m[63:32], m[31:0]);
        end

        issue(3'd4, 32'h12345678, 32'd0);
        chk("mthi_hi", MDU_hi, 32'h12345678);
        chk("mthi_busy", MDU_busy, 0);
        chk("mthi_done", MDU_done, 0);
        issue(3'd5, 32'hCAFEF00D, 32'd0);
        chk("mtlo_lo", MDU_lo, 32'hCAFEF00D);
        chk("mtlo_hi_kept", MDU_hi, 32'h12345678);

        push("divu_mtlo", 32'd6, 32'd142);
        issue(3'd3, 32'd1000, 32'd7);
        t0 = t_iss;
        repeat (9) step();
        chk("hold_hi_busy", MDU_hi, 32'h12345678);
        issue(3'd5, 32'hDEADBEEF, 32'd0);
        chk("mtlo_ignored", MDU_lo, 32'hCAFEF00D);
        wait_done(t0, nb);
        step();

        push("divu_b2b", 32'd5, 32'h19999999);
        issue(3'd3, 32'hFFFFFFFF, 32'd10);
        t0 = t_iss;
        repeat (4) step();
        issue(3'd0, 32'd2, 32'd3);
        repeat (14) step();
        issue(3'd0, 32'd5, 32'd9);
        repeat (12) step();
        chk("b2b_edge32_busy", MDU_busy, 1);
        push("mult_b2b", 32'h00000001, 32'h00000000);
        issue(3'd0, 32'h00010000, 32'h00010000);
        t1 = t_iss;
        chk("b2b_done33", MDU_done, 1);
        chk("b2b_busy33", MDU_busy, 1);
        retire(t0);
        step();
        wait_done(t1, nb);
        chk("b2b_busy_cycles", nb, 32);
        chk("b2b_abs_edge", cyc - t0, 66);
        step();
        chk("b2b_done_pulse", MDU_done, 0);

        issue(3'd1, 32'hFFFFFFFF, 32'd3);
        repeat (9) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("amid_hi", MDU_hi, 0);
        chk("amid_lo", MDU_lo, 0);
        chk("amid_busy", MDU_busy, 0);
        chk("amid_done", MDU_done, 0);
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (MDU_done || MDU_busy) seen = 1'b1;
        end
        chk("arel_quiet", seen, 0);
        chk("arel_hi", MDU_hi, 0);
        chk("arel_lo", MDU_lo, 0);

        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
